acel_text_formatter: RTL and testbench

- Upstream feeder for the character pixel generator in the accelerometer display path.
- Accepts one signed accelerometer axis sample and an axis select, and converts the magnitude to three decimal digits with a sequential double-dabble FSM.
- Holds a 6-character display line: axis letter, '=', sign, hundreds, tens, units.
- For each VGA pixel coordinate, outputs the character code and glyph origin (character_generator, base_x, base_y) that the generator consumes.

---
 rtl/acel_text_formatter_if.sv | 13 +
 rtl/acel_text_formatter.sv | 103 ++++++++++
 tb/tb_acel_text_formatter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/acel_text_formatter_if.sv
// acel_text_formatter_if: sample handshake between the accelerometer reader and the text formatter.
//   sample_valid  single-cycle strobe qualifying sample_data/axis_sel
//   sample_data   signed DATA_W-bit axis reading
//   axis_sel      0=X, 1=Y, 2=Z, 3=X
//   busy          conversion in progress, new samples are dropped
interface acel_text_formatter_if #(parameter int DATA_W = 10);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [1:0]        axis_sel;
  logic              busy;
  modport master (output sample_valid, sample_data, axis_sel, input busy);
  modport slave  (input sample_valid, sample_data, axis_sel, output busy);
endinterface

// File: rtl/acel_text_formatter.sv
// acel_text_formatter: converts a signed axis sample to a 6-character line "A=sDDD" and serves it per pixel.
//   clk                  system/pixel clock
//   rst_n                asynchronous active-low reset
//   sb                   sample handshake (sample_valid, sample_data, axis_sel in; busy out)
//   x, y                 current VGA pixel coordinate
//   character_generator  ASCII code of the slot under (x,y), 8'h00 outside the text line (1-cycle latency)
//   base_x, base_y       glyph origin of that slot, 0 outside the text line
module acel_text_formatter #(
  parameter int DATA_W     = 10,
  parameter int ROW_Y      = 100,
  parameter int COL0_X     = 40,
  parameter int CHAR_PITCH = 80
) (
  input  logic                 clk,
  input  logic                 rst_n,
  acel_text_formatter_if.slave sb,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  output logic [7:0]           character_generator,
  output logic [9:0]           base_x,
  output logic [9:0]           base_y
);
  typedef enum logic [1:0] {IDLE, ABS, CONV, COMMIT} state_t;
  localparam logic [9:0] E0 = 10'(COL0_X);
  localparam logic [9:0] E1 = 10'(COL0_X + 1 * CHAR_PITCH);
  localparam logic [9:0] E2 = 10'(COL0_X + 2 * CHAR_PITCH);
  localparam logic [9:0] E3 = 10'(COL0_X + 3 * CHAR_PITCH);
  localparam logic [9:0] E4 = 10'(COL0_X + 4 * CHAR_PITCH);
  localparam logic [9:0] E5 = 10'(COL0_X + 5 * CHAR_PITCH);
  localparam logic [9:0] E6 = 10'(COL0_X + 6 * CHAR_PITCH);
  localparam logic [9:0] Y0 = 10'(ROW_Y);
  localparam logic [9:0] Y1 = 10'(ROW_Y + 100);
  state_t            st, nxt;
  logic [DATA_W-1:0] smp, mag, cnt;
  logic [1:0]        axis_q;
  logic              neg, in_area;
  logic [11:0]       bcd, adj;
  logic [2:0]        slot;
  logic [9:0]        slot_x;
  logic [7:0]        disp [6];
  always_comb begin
    nxt = st == IDLE ? (sb.sample_valid ? ABS : IDLE) :
          st == ABS  ? CONV :
          st == CONV ? (cnt == DATA_W'(DATA_W - 1) ? COMMIT : CONV) : IDLE;
    sb.busy = st != IDLE;
  end
  // Double-dabble correction applied to every nibble before each shift.
  always_comb begin
    adj = {bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8],
           bcd[7:4]  >= 4'd5 ? bcd[7:4]  + 4'd3 : bcd[7:4],
           bcd[3:0]  >= 4'd5 ? bcd[3:0]  + 4'd3 : bcd[3:0]};
  end
  // Slot selection by range comparators against the fixed slot edges; no divider.
  always_comb begin
    in_area = x >= E0 && x < E6 && y >= Y0 && y < Y1;
    slot    = x < E1 ? 3'd0 : x < E2 ? 3'd1 : x < E3 ? 3'd2 : x < E4 ? 3'd3 : x < E5 ? 3'd4 : 3'd5;
    slot_x  = x < E1 ? E0 : x < E2 ? E1 : x < E3 ? E2 : x < E4 ? E3 : x < E5 ? E4 : E5;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp                 <= '0;
      axis_q              <= '0;
      neg                 <= 1'b0;
      mag                 <= '0;
      bcd                 <= '0;
      cnt                 <= '0;
      disp                <= '{8'h58, 8'h3D, 8'h20, 8'h30, 8'h30, 8'h30};
      character_generator <= 8'h00;
      base_x              <= '0;
      base_y              <= '0;
    end else begin
      if (st == IDLE && sb.sample_valid) begin
        smp    <= sb.sample_data;
        axis_q <= sb.axis_sel;
      end
      // Unsigned DATA_W result, so the most negative sample maps to 2^(DATA_W-1) without overflow.
      if (st == ABS) begin
        neg <= smp[DATA_W-1];
        mag <= smp[DATA_W-1] ? -smp : smp;
        bcd <= '0;
        cnt <= '0;
      end
      if (st == CONV) begin
        {bcd, mag} <= {adj, mag} << 1;
        cnt        <= cnt + 1'b1;
      end
      // Whole line written in one edge so a scan never shows a half-updated value.
      if (st == COMMIT) disp <= '{axis_q == 2'd1 ? 8'h59 : axis_q == 2'd2 ? 8'h5A : 8'h58,
                                 8'h3D,
                                 neg ? 8'h2D : 8'h20,
                                 8'h30 + {4'h0, bcd[11:8]},
                                 8'h30 + {4'h0, bcd[7:4]},
                                 8'h30 + {4'h0, bcd[3:0]}};
      character_generator <= in_area ? disp[slot] : 8'h00;
      base_x              <= in_area ? slot_x : 10'd0;
      base_y              <= in_area ? Y0 : 10'd0;
    end
  end
endmodule

// File: tb/tb_acel_text_formatter.sv
// tb_acel_text_formatter: self-checking bench for acel_text_formatter against a decimal/geometry model.
module tb_acel_text_formatter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic [7:0] character_generator;
  logic [9:0] base_x, base_y;
  int         n_chk = 0, n_fail = 0;
  logic [7:0] exp_buf [6];
  typedef struct {
    int x, y, ch, bx, by;
  } vec_t;
  vec_t vecs [10];
  acel_text_formatter_if #(.DATA_W(10)) sb ();
  acel_text_formatter dut (
    .clk(clk), .rst_n(rst_n), .sb(sb), .x(x), .y(y),
    .character_generator(character_generator), .base_x(base_x), .base_y(base_y)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask
  function automatic void set_line(input int v, input int ax);
    int m;
    m = v < 0 ? -v : v;
    exp_buf[0] = ax == 1 ? "Y" : ax == 2 ? "Z" : "X";
    exp_buf[1] = "=";
    exp_buf[2] = v < 0 ? "-" : " ";
    exp_buf[3] = 8'(48 + m / 100);
    exp_buf[4] = 8'(48 + (m / 10) % 10);
    exp_buf[5] = 8'(48 + m % 10);
  endfunction
  task automatic pix_model(input int px, input int py, output int ch, output int bx, output int by);
    int s;
    if (px >= 40 && px < 520 && py >= 100 && py < 200) begin
      s  = (px - 40) / 80;
      ch = int'(exp_buf[s]);
      bx = 40 + 80 * s;
      by = 100;
    end else begin
      ch = 0; bx = 0; by = 0;
    end
  endtask
  task automatic probe(input int px, input int py, input int ch, input int bx, input int by, input string nm);
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    @(negedge clk);
    chk({nm, " char"}, int'(character_generator), ch);
    chk({nm, " base_x"}, int'(base_x), bx);
    chk({nm, " base_y"}, int'(base_y), by);
  endtask
  task automatic probe_model(input int px, input int py, input string nm);
    int ch, bx, by;
    pix_model(px, py, ch, bx, by);
    probe(px, py, ch, bx, by, nm);
  endtask
  task automatic check_line(input string nm);
    for (int k = 0; k < 6; k++)
      probe_model(40 + 80 * k + int'($urandom_range(0, 79)), 100 + int'($urandom_range(0, 99)), nm);
  endtask
  task automatic send(input int v, input int ax);
    @(negedge clk);
    sb.sample_valid = 1'b1;
    sb.sample_data  = 10'(v);
    sb.axis_sel     = 2'(ax);
    @(negedge clk);
    sb.sample_valid = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (sb.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic convert(input int v, input int ax, input string nm);
    int n;
    send(v, ax);
    wait_idle(n);
    chk({nm, " busy cycles"}, n, 12);
    set_line(v, ax);
    check_line(nm);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n, v, ax;
    sb.sample_valid = 1'b0;
    sb.sample_data  = '0;
    sb.axis_sel     = '0;
    vecs = '{
      '{40, 100, 8'h58, 40, 100}, '{360, 100, 8'h30, 360, 100}, '{39, 100, 0, 0, 0},
      '{520, 150, 0, 0, 0}, '{100, 99, 0, 0, 0}, '{100, 200, 0, 0, 0},
      '{519, 100, 8'h30, 440, 100}, '{119, 199, 8'h58, 40, 100},
      '{120, 100, 8'h3D, 120, 100}, '{200, 150, 8'h20, 200, 100}};
    repeat (3) @(negedge clk);
    chk("reset busy", int'(sb.busy), 0);
    chk("reset char", int'(character_generator), 0);
    chk("reset base_x", int'(base_x), 0);
    chk("reset base_y", int'(base_y), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++)
      probe(vecs[i].x, vecs[i].y, vecs[i].ch, vecs[i].bx, vecs[i].by, $sformatf("vec%0d", i));
    // 123 on Y; the slot under the beam switches only after busy has fallen.
    probe(440, 150, 8'h30, 440, 100, "pre123");
    send(123, 1);
    wait_idle(n);
    chk("y123 busy cycles", n, 12);
    chk("atomic old char", int'(character_generator), 8'h30);
    @(negedge clk);
    chk("atomic new char", int'(character_generator), 8'h33);
    set_line(123, 1);
    probe(440, 150, 8'h33, 440, 100, "y123 units");
    check_line("y123");
    convert(-512, 2, "z-512");
    probe(200, 100, 8'h2D, 200, 100, "z-512 sign");
    // Second sample arrives while busy and must be dropped.
    send(45, 0);
    repeat (2) @(negedge clk);
    send(7, 1);
    wait_idle(n);
    repeat (15) @(negedge clk);
    chk("dropped sample busy", int'(sb.busy), 0);
    set_line(45, 0);
    check_line("x45");
    // Reset in the middle of a conversion.
    send(300, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", int'(sb.busy), 0);
    chk("abort char", int'(character_generator), 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_line(0, 0);
    check_line("after abort");
    convert(9, 0, "x9");
    for (int i = 0; i < 20; i++) begin
      v  = int'($urandom_range(0, 1023)) - 512;
      ax = int'($urandom_range(0, 3));
      convert(v, ax, $sformatf("rand%0d(%0d)", i, v));
    end
    for (int i = 0; i < 60; i++)
      probe_model(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), $sformatf("scan%0d", i));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
